// File: rtl/lc3_mem_unit.sv
// lc3_mem_unit
// Memory stage of the LC-3 datapath. Holds the MAR and MDR registers and a
// word-addressed 16-bit memory with a fixed access latency. An accepted
// access completes LATENCY clocks later. Completion is flagged by a
// one-cycle mem_ready pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus_in     datapath bus, source for MAR/MDR loads
//   ld_mar     load MAR from bus_in
//   ld_mdr     load MDR from bus_in (ignored while mem_en=1 or busy)
//   mem_en     request an access (accepted only when idle)
//   mem_rw     access type: 0 = read, 1 = write
//   gate_mdr   drive MDR onto bus_out
//   bus_out    MDR when gate_mdr=1, else 0 (combinational)
//   bus_drive  equals gate_mdr
//   mar_out    current MAR
//   mdr_out    current MDR
//   busy       high while an access is in flight
//   mem_ready  one-cycle completion pulse
module lc3_mem_unit #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mem_en,
    input  logic        mem_rw,
    input  logic        gate_mdr,
    output logic [15:0] bus_out,
    output logic        bus_drive,
    output logic [15:0] mar_out,
    output logic [15:0] mdr_out,
    output logic        busy,
    output logic        mem_ready
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [15:0]       mar_reg;
    logic [15:0]       mdr_reg;
    logic              op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       wdata_reg;
    logic              busy_reg;
    logic              ready_reg;

    logic [15:0] mem [DEPTH];

    logic [15:0] mar_next;
    logic        complete;
    logic        mem_we;

    // An access accepted on the same edge as ld_mar must use the new MAR.
    assign mar_next = ld_mar ? bus_in : mar_reg;
    assign complete = (state_reg == S_ACCESS) && (cnt_reg == '0);
    // Gating with rst_n ensures that an aborted write cannot land in memory.
    // This also covers a completion edge that coincides with reset assertion.
    assign mem_we   = complete && op_reg && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            mar_reg   <= 16'h0000;
            mdr_reg   <= 16'h0000;
            op_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 16'h0000;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (ld_mar) begin
                        mar_reg <= bus_in;
                    end
                    if (mem_en) begin
                        op_reg    <= mem_rw;
                        addr_reg  <= mar_next[ADDR_W-1:0];
                        wdata_reg <= mdr_reg;
                        cnt_reg   <= CNT_INIT;
                        busy_reg  <= 1'b1;
                        state_reg <= S_ACCESS;
                    end else if (ld_mdr) begin
                        mdr_reg <= bus_in;
                    end
                end
                S_ACCESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        if (!op_reg) begin
                            mdr_reg <= mem[addr_reg];
                        end
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    assign bus_out   = gate_mdr ? mdr_reg : 16'h0000;
    assign bus_drive = gate_mdr;
    assign mar_out   = mar_reg;
    assign mdr_out   = mdr_reg;
    assign busy      = busy_reg;
    assign mem_ready = ready_reg;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Testbench for lc3_mem_unit. There are two instances: index 0 uses
// LATENCY=2 and index 1 uses LATENCY=3, and both use ADDR_W=8. The expected
// values come from a reference model made of a word array plus MAR/MDR
// variables.
module tb_lc3_mem_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [1:0][15:0]      bus_in;
    logic [1:0][15:0]      bus_out;
    logic [1:0][15:0]      mar_out;
    logic [1:0][15:0]      mdr_out;
    logic [1:0]            ld_mar, ld_mdr, mem_en, mem_rw, gate_mdr;
    logic [1:0]            bus_drive, busy, mem_ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem   [2][256];
    bit          ref_valid [2][256];
    logic [15:0] ref_mar   [2];
    logic [15:0] ref_mdr   [2];

    lc3_mem_unit #(.ADDR_W(8), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in[0]), .ld_mar(ld_mar[0]),
        .ld_mdr(ld_mdr[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
        .gate_mdr(gate_mdr[0]), .bus_out(bus_out[0]), .bus_drive(bus_drive[0]),
        .mar_out(mar_out[0]), .mdr_out(mdr_out[0]), .busy(busy[0]),
        .mem_ready(mem_ready[0])
    );

    lc3_mem_unit #(.ADDR_W(8), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in[1]), .ld_mar(ld_mar[1]),
        .ld_mdr(ld_mdr[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
        .gate_mdr(gate_mdr[1]), .bus_out(bus_out[1]), .bus_drive(bus_drive[1]),
        .mar_out(mar_out[1]), .mdr_out(mdr_out[1]), .busy(busy[1]),
        .mem_ready(mem_ready[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            ref_mar[s] = 16'h0000;
            ref_mdr[s] = 16'h0000;
        end
    endtask

    task automatic load(input int s, input bit lm, input bit ld, input logic [15:0] v);
        bus_in[s] = v;
        ld_mar[s] = lm;
        ld_mdr[s] = ld;
        tick();
        ld_mar[s] = 1'b0;
        ld_mdr[s] = 1'b0;
        if (lm) ref_mar[s] = v;
        if (ld) ref_mdr[s] = v;
    endtask

    // Performs one access and checks its latency, busy, the result, and the pulse width.
    task automatic access(input int s, input bit rw, input bit lm, input logic [15:0] v,
                          input string nm);
        int k;
        int a;
        int lat;
        lat = (s == 0) ? 2 : 3;
        bus_in[s] = v;
        ld_mar[s] = lm;
        mem_en[s] = 1'b1;
        mem_rw[s] = rw;
        tick();
        ld_mar[s] = 1'b0;
        mem_en[s] = 1'b0;
        if (lm) ref_mar[s] = v;
        a = int'(ref_mar[s][7:0]);
        k = 0;
        while (mem_ready[s] !== 1'b1 && k < 20) begin
            total++;
            if (busy[s] !== 1'b1) begin
                bad++;
                $display("FAIL %s busy k=%0d got=%b want=1", nm, k, busy[s]);
            end
            tick();
            k++;
        end
        if (rw) begin
            ref_mem[s][a]   = ref_mdr[s];
            ref_valid[s][a] = 1'b1;
        end else begin
            ref_mdr[s] = ref_mem[s][a];
        end
        total++;
        if (k !== lat) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", nm, k, lat);
        end
        total++;
        if (mdr_out[s] !== ref_mdr[s]) begin
            bad++;
            $display("FAIL %s mdr got=%h want=%h", nm, mdr_out[s], ref_mdr[s]);
        end
        total++;
        if (mar_out[s] !== ref_mar[s]) begin
            bad++;
            $display("FAIL %s mar got=%h want=%h", nm, mar_out[s], ref_mar[s]);
        end
        total++;
        if (busy[s] !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_ready got=%b want=0", nm, busy[s]);
        end
        if (gate_mdr[s]) begin
            total++;
            if (bus_out[s] !== ref_mdr[s] || bus_drive[s] !== 1'b1) begin
                bad++;
                $display("FAIL %s bus_out got=%h/%b want=%h/1", nm, bus_out[s], bus_drive[s], ref_mdr[s]);
            end
        end
        tick();
        total++;
        if (mem_ready[s] !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_width got=%b want=0", nm, mem_ready[s]);
        end
        $display("txn %s dut=%0d %s addr=%h mar=%h mdr=%h lat=%0d", nm, s,
                 rw ? "WR" : "RD", a[7:0], mar_out[s], mdr_out[s], k);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            load(s, 1, 1, 16'hA5C3 + 16'(s));
            gate_mdr[s] = 1'b1;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            total++;
            if (mar_out[s] !== 16'h0 || mdr_out[s] !== 16'h0 || busy[s] !== 1'b0 ||
                mem_ready[s] !== 1'b0 || bus_out[s] !== 16'h0) begin
                bad++;
                $display("FAIL reset dut=%0d got mar=%h mdr=%h busy=%b rdy=%b bus=%h want all 0",
                         s, mar_out[s], mdr_out[s], busy[s], mem_ready[s], bus_out[s]);
            end
            gate_mdr[s] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("txn reset async check done");
    endtask

    task automatic test_write_read();
        load(0, 1, 0, 16'h0010);
        load(0, 0, 1, 16'hBEEF);
        access(0, 1, 0, 16'h0, "wr_beef");
        load(0, 0, 1, 16'h0000);
        gate_mdr[0] = 1'b1;
        access(0, 0, 0, 16'h0, "rd_beef");
        gate_mdr[0] = 1'b0;
        total++;
        if (mdr_out[0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL rd_beef_const got=%h want=beef", mdr_out[0]);
        end
    endtask

    task automatic test_alias();
        load(0, 1, 1, 16'h0105);
        load(0, 0, 1, 16'h1234);
        access(0, 1, 0, 16'h0, "wr_alias");
        load(0, 1, 1, 16'h0005);
        load(0, 0, 1, 16'h0000);
        access(0, 0, 0, 16'h0, "rd_alias");
        total++;
        if (mdr_out[0] !== 16'h1234) begin
            bad++;
            $display("FAIL alias got=%h want=1234", mdr_out[0]);
        end
    endtask

    task automatic test_ld_mar_combined();
        load(0, 1, 0, 16'h0130);
        load(0, 0, 1, 16'($urandom));
        access(0, 1, 0, 16'h0, "wr_30");
        load(0, 1, 1, 16'h0000);
        access(0, 0, 1, 16'h0030, "ldmar_rd_30");
        total++;
        if (mar_out[0] !== 16'h0030) begin
            bad++;
            $display("FAIL ldmar_combined mar got=%h want=0030", mar_out[0]);
        end
    endtask

    task automatic test_lockout();
        load(1, 1, 0, 16'h0022);
        load(1, 0, 1, 16'hAAAA);
        access(1, 1, 0, 16'h0, "wr_aaaa");
        load(1, 0, 1, 16'h0000);
        mem_en[1] = 1'b1;
        mem_rw[1] = 1'b0;
        tick();
        mem_en[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin bus_in[1] = 16'h0020; ld_mar[1] = 1'b1; end
            if (i == 2) begin bus_in[1] = 16'h5555; ld_mdr[1] = 1'b1; end
            if (i == 3) mem_en[1] = 1'b1;
            tick();
            ld_mar[1] = 1'b0;
            ld_mdr[1] = 1'b0;
            mem_en[1] = 1'b0;
            total++;
            if (mem_ready[1] !== (i == 3)) begin
                bad++;
                $display("FAIL lockout ready cyc=%0d got=%b want=%b", i, mem_ready[1], (i == 3));
            end
        end
        ref_mdr[1] = ref_mem[1][8'h22];
        total++;
        if (mar_out[1] !== 16'h0022 || mdr_out[1] !== 16'hAAAA) begin
            bad++;
            $display("FAIL lockout regs got mar=%h mdr=%h want mar=0022 mdr=aaaa",
                     mar_out[1], mdr_out[1]);
        end
        $display("txn lockout dut=1 mar=%h mdr=%h", mar_out[1], mdr_out[1]);
    endtask

    task automatic test_back_to_back();
        load(0, 1, 0, 16'h0010);
        mem_en[0] = 1'b1;
        mem_rw[0] = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            tick();
            total++;
            if (mem_ready[0] !== ((i % 3) == 2)) begin
                bad++;
                $display("FAIL b2b ready edge=%0d got=%b want=%b", i, mem_ready[0], ((i % 3) == 2));
            end
        end
        mem_en[0] = 1'b0;
        tick();
        ref_mdr[0] = ref_mem[0][8'h10];
        total++;
        if (busy[0] !== 1'b0 || mdr_out[0] !== ref_mdr[0]) begin
            bad++;
            $display("FAIL b2b end got busy=%b mdr=%h want busy=0 mdr=%h", busy[0], mdr_out[0], ref_mdr[0]);
        end
        $display("txn back_to_back dut=0 three reads mdr=%h", mdr_out[0]);
    endtask

    task automatic test_random();
        int a;
        int tries;
        logic [15:0] hi;
        for (int n = 0; n < 30; n++) begin
            hi = 16'($urandom_range(0, 255)) << 8;
            if ($urandom_range(0, 2) == 0 || n < 4) begin
                a = $urandom_range(0, 255);
                load(0, 0, 1, 16'($urandom));
                if ($urandom_range(0, 1) == 1) begin
                    access(0, 1, 1, hi | 16'(a), "rnd_wr");
                end else begin
                    load(0, 1, 0, hi | 16'(a));
                    access(0, 1, 0, 16'h0, "rnd_wr");
                end
            end else begin
                tries = 0;
                a = $urandom_range(0, 255);
                while (!ref_valid[0][a] && tries < 1000) begin
                    a = (a + 1) % 256;
                    tries++;
                end
                load(0, 0, 1, 16'($urandom));
                access(0, 0, 1, hi | 16'(a), "rnd_rd");
            end
        end
    endtask

    task automatic test_reset_mid_write();
        load(0, 1, 1, 16'h0040);
        load(0, 0, 1, 16'h0001);
        access(0, 1, 0, 16'h0, "wr_0001");
        load(0, 0, 1, 16'hDEAD);
        mem_en[0] = 1'b1;
        mem_rw[0] = 1'b1;
        tick();
        mem_en[0] = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_ready[0] !== 1'b0 || mdr_out[0] !== 16'h0) begin
                bad++;
                $display("FAIL rst_mid_write cyc=%0d got rdy=%b mdr=%h want 0/0000", i, mem_ready[0], mdr_out[0]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        #6;
        if (mem_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_release got rdy=%b busy=%b want 0/0", mem_ready[0], busy[0]);
        end
        load(0, 1, 0, 16'h0040);
        access(0, 0, 0, 16'h0, "rd_after_abort");
        total++;
        if (mdr_out[0] !== 16'h0001) begin
            bad++;
            $display("FAIL abort_no_write got=%h want=0001", mdr_out[0]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus_in   = '0;
        ld_mar   = '0;
        ld_mdr   = '0;
        mem_en   = '0;
        mem_rw   = '0;
        gate_mdr = '0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                ref_valid[s][a] = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        test_reset();
        test_write_read();
        test_alias();
        test_ld_mar_combined();
        test_lockout();
        test_back_to_back();
        test_random();
        test_reset_mid_write();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
